// File: rtl/rgb_ramp_ctrl_if.sv
// Target-colour handshake between a colour source and the RGB ramp controller.
interface rgb_ramp_ctrl_if #(
  parameter int BITS = 8
);
  logic            tgt_valid;
  logic            tgt_ready;
  logic [BITS-1:0] tgt_red;
  logic [BITS-1:0] tgt_green;
  logic [BITS-1:0] tgt_blue;

  modport master (
    output tgt_valid, tgt_red, tgt_green, tgt_blue,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid, tgt_red, tgt_green, tgt_blue,
    output tgt_ready
  );
endinterface

// File: rtl/rgb_ramp_ctrl.sv
// RGB level generator: accepts a target colour and slews each channel one LSB
// per STEP_DIV clocks toward it, then pulses done for one cycle.
module rgb_ramp_ctrl #(
  parameter int BITS     = 8,
  parameter int STEP_DIV = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rgb_ramp_ctrl_if.slave   tgt,
  output logic [BITS-1:0]  level_red,
  output logic [BITS-1:0]  level_green,
  output logic [BITS-1:0]  level_blue,
  output logic             busy,
  output logic             done
);

  localparam int                 TICK_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [TICK_W-1:0]  TICK_MAX = TICK_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [TICK_W-1:0] tick;
  logic [BITS-1:0] lvl_q   [3];
  logic [BITS-1:0] tgt_q   [3];
  logic [BITS-1:0] lvl_nxt [3];
  logic [BITS-1:0] in_tgt  [3];
  logic            step_now;
  logic            nxt_at_tgt;
  logic            in_at_lvl;

  // Saturating by construction: a channel only moves toward its target.
  function automatic logic [BITS-1:0] step_toward(input logic [BITS-1:0] cur,
                                                  input logic [BITS-1:0] goal);
    if (cur < goal)      return cur + BITS'(1);
    else if (cur > goal) return cur - BITS'(1);
    else                 return cur;
  endfunction

  always_comb begin
    in_tgt[0] = tgt.tgt_red;
    in_tgt[1] = tgt.tgt_green;
    in_tgt[2] = tgt.tgt_blue;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    nxt_at_tgt = 1'b1;
    in_at_lvl  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      lvl_nxt[c] = step_toward(lvl_q[c], tgt_q[c]);
      if (lvl_nxt[c] != tgt_q[c]) nxt_at_tgt = 1'b0;
      if (in_tgt[c] != lvl_q[c])  in_at_lvl  = 1'b0;
    end
  end

  assign step_now = (tick == TICK_MAX);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tick  <= '0;
      for (int c = 0; c < 3; c++) begin
        lvl_q[c] <= '0;
        tgt_q[c] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (tgt.tgt_valid) begin
            tick <= '0;
            for (int c = 0; c < 3; c++) tgt_q[c] <= in_tgt[c];
            state <= in_at_lvl ? DONE : RAMP;
          end
        end
        RAMP: begin
          tick <= step_now ? '0 : tick + TICK_W'(1);
          if (step_now) begin
            for (int c = 0; c < 3; c++) lvl_q[c] <= lvl_nxt[c];
            if (nxt_at_tgt) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tgt.tgt_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign level_red     = lvl_q[0];
  assign level_green   = lvl_q[1];
  assign level_blue    = lvl_q[2];

endmodule

// File: tb/tb_rgb_ramp_ctrl.sv
// Bench for rgb_ramp_ctrl: STEP_DIV=4 and STEP_DIV=1 instances checked every
// cycle against a closed-form ramp model (level = start +/- min(k/STEP_DIV, dist)).
module tb_rgb_ramp_ctrl;

  localparam int BITS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_ramp_ctrl_if #(.BITS(BITS)) if4 ();
  rgb_ramp_ctrl_if #(.BITS(BITS)) if1 ();

  logic [BITS-1:0] lr4, lg4, lb4, lr1, lg1, lb1;
  logic            busy4, done4, busy1, done1;

  rgb_ramp_ctrl #(.BITS(BITS), .STEP_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tgt(if4.slave),
    .level_red(lr4), .level_green(lg4), .level_blue(lb4),
    .busy(busy4), .done(done4)
  );

  rgb_ramp_ctrl #(.BITS(BITS), .STEP_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt(if1.slave),
    .level_red(lr1), .level_green(lg1), .level_blue(lb1),
    .busy(busy1), .done(done1)
  );

  // Shared stimulus; sel picks which instance sees tgt_valid and is observed.
  logic            sel = 1'b0;
  logic            vld = 1'b0;
  logic [BITS-1:0] in_r = '0, in_g = '0, in_b = '0;

  assign if4.tgt_valid = vld && !sel;
  assign if4.tgt_red   = in_r;
  assign if4.tgt_green = in_g;
  assign if4.tgt_blue  = in_b;
  assign if1.tgt_valid = vld && sel;
  assign if1.tgt_red   = in_r;
  assign if1.tgt_green = in_g;
  assign if1.tgt_blue  = in_b;

  logic [23:0] obs_lvl;
  logic [2:0]  obs_st;  // {busy, done, tgt_ready}
  always_comb begin
    obs_lvl = sel ? {lr1, lg1, lb1} : {lr4, lg4, lb4};
    obs_st  = sel ? {busy1, done1, if1.tgt_ready} : {busy4, done4, if4.tgt_ready};
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: current levels per instance and ramp arithmetic.
  int cur [2][3];
  int sdiv [2] = '{4, 1};

  function automatic int model_level(input int from, input int to, input int k, input int s);
    int n = k / s;
    int d = to - from;
    if (d >= 0) return from + ((n < d) ? n : d);
    else        return from - ((n < -d) ? n : -d);
  endfunction

  function automatic int model_dlast(input int s, input int r, input int g, input int b, input int idx);
    int tg [3];
    int m = 0;
    tg = '{r, g, b};
    for (int c = 0; c < 3; c++) begin
      int a = tg[c] - cur[idx][c];
      if (a < 0) a = -a;
      if (a > m) m = a;
    end
    return m * s;
  endfunction

  // Called in the low clock phase; returns just after a negedge.
  task automatic do_transfer(input int r, input int g, input int b, input int dlast,
                             input bit hold, input int hr, input int hg, input int hb);
    int idx = sel ? 1 : 0;
    int s = sdiv[idx];
    int fr [3];
    int tg [3];
    logic [23:0] e_lvl;
    logic [2:0]  e_st;
    for (int c = 0; c < 3; c++) fr[c] = cur[idx][c];
    tg = '{r, g, b};
    vld  = 1'b1;
    in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
    check("ready_before_transfer", 32'(obs_st), 32'(3'b001));
    @(posedge clk);
    for (int k = 0; k <= dlast + 1; k++) begin
      @(negedge clk);
      e_lvl = {8'(model_level(fr[0], tg[0], k, s)),
               8'(model_level(fr[1], tg[1], k, s)),
               8'(model_level(fr[2], tg[2], k, s))};
      e_st  = (k < dlast) ? 3'b100 : (k == dlast) ? 3'b110 : 3'b001;
      check($sformatf("level sd=%0d k=%0d", s, k), 32'(obs_lvl), 32'(e_lvl));
      check($sformatf("status sd=%0d k=%0d", s, k), 32'(obs_st), 32'(e_st));
      if (k == 0) begin
        vld = hold;
        if (hold) begin
          in_r = 8'(hr); in_g = 8'(hg); in_b = 8'(hb);
        end else begin
          in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
        end
      end
    end
    for (int c = 0; c < 3; c++) cur[idx][c] = tg[c];
  endtask

  task automatic reset_midramp();
    sel  = 1'b0;
    vld  = 1'b1;
    in_r = 8'd250; in_g = 8'd250; in_b = 8'd250;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      vld = 1'b0;
    end
    check("midramp_level_before_reset", 32'(obs_lvl), 32'({8'd254, 8'd254, 8'd254}));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_level", 32'(obs_lvl), 32'd0);
    check("async_reset_status", 32'(obs_st), 32'(3'b001));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cur[0][c] = 0;
      cur[1][c] = 0;
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("post_reset_hold k=%0d", k), 32'({obs_lvl, obs_st}), 32'({24'd0, 3'b001}));
    end
  endtask

  typedef struct {
    bit sel;
    int r, g, b;
    int dlast;
    bit hold;
    int hr, hg, hb;
    int fr, fg, fb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b0,   3,   1,   0,   12, 1'b0,   0,   0,   0,   3,   1,   0};
    vecs[1] = '{1'b0,   0,   1,   2,   12, 1'b0,   0,   0,   0,   0,   1,   2};
    vecs[2] = '{1'b0,   0,   1,   2,    0, 1'b0,   0,   0,   0,   0,   1,   2};
    vecs[3] = '{1'b0,   3,   1,   0,   12, 1'b1, 255, 255, 255,   3,   1,   0};
    vecs[4] = '{1'b0, 255, 255, 255, 1020, 1'b0,   0,   0,   0, 255, 255, 255};
    vecs[5] = '{1'b1, 255,   0, 128,  255, 1'b0,   0,   0,   0, 255,   0, 128};

    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 3; c++) cur[i][c] = 0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check($sformatf("reset_level dut%0d", i), 32'(obs_lvl), 32'd0);
      check($sformatf("reset_status dut%0d", i), 32'(obs_st), 32'(3'b001));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sel   = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (i == 5) reset_midramp();
      sel = vecs[i].sel;
      do_transfer(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].dlast,
                  vecs[i].hold, vecs[i].hr, vecs[i].hg, vecs[i].hb);
      check($sformatf("final_level row%0d", i), 32'(obs_lvl),
            32'({8'(vecs[i].fr), 8'(vecs[i].fg), 8'(vecs[i].fb)}));
    end

    for (int n = 0; n < 10; n++) begin
      int r, g, b, idx;
      sel = (n >= 6);
      idx = sel ? 1 : 0;
      r = $urandom_range(255);
      g = $urandom_range(255);
      b = (n % 3 == 0) ? cur[idx][2] : $urandom_range(255);
      do_transfer(r, g, b, model_dlast(sdiv[idx], r, g, b, idx), 1'b0, 0, 0, 0);
    end

    vld = 1'b0;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_ramp_ctrl.md
Name: rgb_ramp_ctrl

Overview:
- Upstream level generator for the RGB LED path. Drives the 8-bit level inputs of the three per-channel PWM stages.
- Accepts a target colour over a valid/ready handshake, then slews each channel's level one LSB per step toward its target.
- Steps occur once every STEP_DIV clocks. Signals completion with a one-cycle done pulse.
- Replaces the fixed up/down triangle sweep with command-driven, smooth colour transitions.

Parameters:
- BITS, 8: width of each level and target channel; matches the PWM stage BITS.
- STEP_DIV, 16: clock cycles per ramp step. Legal range 1..65535. Tick counter width is clog2(STEP_DIV), minimum 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tgt_valid  in  1  target colour present on the tgt_* buses.
- tgt_ready  out  1  block can accept a target; high only in IDLE.
- tgt_red  in  BITS  target red level.
- tgt_green  in  BITS  target green level.
- tgt_blue  in  BITS  target blue level.
- level_red  out  BITS  current red level, registered; to the PWM stage.
- level_green  out  BITS  current green level, registered.
- level_blue  out  BITS  current blue level, registered.
- busy  out  1  high in RAMP and DONE.
- done  out  1  one-cycle pulse, high only in DONE.

Behaviour:
- Reset, asserted asynchronously:
  - state = IDLE; all levels = 0; latched targets = 0; tick = 0.
  - busy = 0, done = 0, tgt_ready = 1.
  - Reset mid-ramp: levels jump to 0 immediately; the in-flight target is discarded.
- States and outputs:
  - Three states: IDLE, RAMP, DONE.
  - tgt_ready = (state == IDLE). busy = (state != IDLE). done = (state == DONE). All are decoded from the state register only.
- IDLE:
  - A transfer occurs on a rising edge where tgt_valid && tgt_ready.
  - On the transfer: latch all three targets and clear tick.
  - If all three targets equal the current levels, next state = DONE; otherwise next state = RAMP.
  - Levels hold in IDLE.
- RAMP:
  - tick increments each cycle and wraps from STEP_DIV-1 to 0.
  - On the edge where tick == STEP_DIV-1, each channel independently moves one step:
    - level < target: level + 1.
    - level > target: level - 1.
    - level == target: hold.
  - No overshoot, no wrap; levels stay within 0..2^BITS-1.
  - The next-level values are computed combinationally. If all next levels equal the targets, the state goes to DONE on that same edge.
  - tgt_valid is ignored (tgt_ready = 0); the tgt_* buses are not sampled.
- DONE: lasts exactly one cycle, then IDLE. A new transfer is possible on the edge after leaving DONE.
- Latency:
  - Transfer at edge E0, with D = max over channels of |target - level|.
  - D > 0: the final update is at edge E0 + D*STEP_DIV. done is high for the cycle following that edge, and tgt_ready returns 1 one cycle later.
  - D = 0: done is high for the cycle following E0.
- STEP_DIV = 1: a step occurs every RAMP cycle.
- Tick width rule: tick compare uses the full clog2 width. No truncation at STEP_DIV equal to a power of two.
- Channels with smaller distance reach their target early and hold while the others finish.

Test Plan:
1. STEP_DIV=4, from reset, send (3,1,0) → transfer at E0. Level updates at E0+4, +8, +12:
   - red 1,2,3; green 1,1,1; blue 0.
   - done high exactly one cycle after E0+12; tgt_ready low throughout, high again after DONE.
2. From (3,1,0), send (0,1,2) → red 2,1,0; blue 1,2,(hold); green constant 1. done after E0+12.
3. Send a target equal to the current levels → state skips RAMP; done pulses the cycle after the transfer; levels never change.
4. During scenario 1, hold tgt_valid=1 with (255,255,255) → ignored. After done, the pulse and the 1-cycle DONE delay elapse, then that target is accepted.
5. Assert rst_n low mid-ramp, between steps → levels 0, busy 0, tgt_ready 1 asynchronously. After release, no further steps until a new transfer.
6. STEP_DIV=1, 0 → (255,0,128) → red reaches 255 at E0+255 with no wrap to 0. Blue holds 128 from E0+128. done once after E0+255.
